serial_subtractor_16bit: RTL and testbench



---
 rtl/serial_subtractor_16bit.sv | 91 +++++++++
 tb/tb_serial_subtractor_16bit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_16bit.sv
// Multi-cycle subtractor: diff = a - b - bin, DIGIT bits per clock from LSB to MSB,
// ripple borrow held in a register, start/busy/done handshake.
module serial_subtractor_16bit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic             brw;
    logic [CW-1:0]    k;

    logic [DIGIT-1:0] dd;
    logic             bo;
    logic [WIDTH-1:0] acc_next;

    // Operands shift right each step, so the current digit is always the low DIGIT bits;
    // the partial difference enters acc from the top and is fully aligned after N steps.
    always_comb begin
        {bo, dd} = {1'b0, op_a[DIGIT-1:0]} - {1'b0, op_b[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw};
        acc_next = {dd, acc[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            brw   <= 1'b0;
            k     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        brw   <= bin;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    op_a <= op_a >> DIGIT;
                    op_b <= op_b >> DIGIT;
                    acc  <= acc_next;
                    brw  <= bo;
                    k    <= k + CW'(1);
                    if (k == LAST) begin
                        // On the last digit op_a/op_b low digits hold the original sign bits.
                        diff  <= acc_next;
                        bout  <= bo;
                        ovf   <= (op_a[DIGIT-1] != op_b[DIGIT-1]) && (dd[DIGIT-1] != op_a[DIGIT-1]);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// Self-checking bench: per-cycle comparison against a timeline model of the
// subtractor, plus literal expectations for the hand-worked vectors.
module tb_serial_subtractor_16bit;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        bin = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    serial_subtractor_16bit #(.WIDTH(16), .DIGIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an accepted start at edge T yields its result at edge T+N.
    int          ecount = 0;
    int          done_at = 0;
    logic        m_busy = 1'b0, m_done = 1'b0, m_bout = 1'b0, m_ovf = 1'b0;
    logic [15:0] m_diff = '0;
    logic [15:0] p_diff;
    logic        p_bout, p_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_diff = '0; m_bout = 1'b0; m_ovf = 1'b0;
        end else begin
            ecount++;
            m_done = 1'b0;
            if (m_busy && ecount == done_at) begin
                m_diff = p_diff; m_bout = p_bout; m_ovf = p_ovf;
                m_done = 1'b1;
                m_busy = 1'b0;
            end else if (!m_busy && start) begin
                logic [16:0] r;
                r = {1'b0, a} - {1'b0, b} - {16'b0, bin};
                p_diff = r[15:0];
                p_bout = r[16];
                p_ovf  = (a[15] != b[15]) && (r[15] != a[15]);
                done_at = ecount + N;
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk1("busy", busy, m_busy);
            chk1("done", done, m_done);
            chk16("diff", diff, m_diff);
            chk1("bout", bout, m_bout);
            chk1("ovf", ovf, m_ovf);
        end
    end

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                          input logic [15:0] ed, input logic ebo, input logic eov);
        int cyc;
        @(negedge clk);
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; bin = $urandom_range(0, 1);
        cyc = 0;
        while (busy && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        chk16("busy_cycles", cyc[15:0], 16'd4);
        chk1("done_pulse", done, 1'b1);
        chk16("lit_diff", diff, ed);
        chk1("lit_bout", bout, ebo);
        chk1("lit_ovf", ovf, eov);
        @(negedge clk);
        chk1("done_one_cycle", done, 1'b0);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hffff;
            2: return 16'h8000;
            3: return 16'h7fff;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk16("rst_diff", diff, 16'h0000);
        chk1("rst_bout", bout, 1'b0);
        chk1("rst_ovf", ovf, 1'b0);
        cmp_en = 1'b1;
        rst_n = 1'b1;

        run_op(16'h8fff, 16'h8000, 1'b0, 16'h0fff, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0002, 1'b1, 16'hfffd, 1'b1, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 16'h7fff, 1'b0, 1'b1);
        run_op(16'h7fff, 16'hffff, 1'b0, 16'h8000, 1'b1, 1'b1);
        run_op(16'h5556, 16'h5555, 1'b1, 16'h0000, 1'b0, 1'b0);
        run_op(16'h0000, 16'hffff, 1'b1, 16'h0000, 1'b1, 1'b0);

        // start held high with new operands every cycle
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b1; a = pick(); b = pick(); bin = $urandom_range(0, 1);
        end
        @(negedge clk);
        start = 1'b0;

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0); a = pick(); b = pick(); bin = $urandom_range(0, 1);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);

        run_op(16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0);

        // abandon an operation with an asynchronous reset between edges
        @(negedge clk);
        a = 16'h0001; b = 16'h0002; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("async_busy", busy, 1'b0);
        chk16("async_diff", diff, 16'h0000);
        chk1("async_bout", bout, 1'b0);
        chk1("async_ovf", ovf, 1'b0);
        repeat (6) begin
            @(negedge clk);
            chk1("no_done_in_reset", done, 1'b0);
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk1("no_done_after_abort", done, 1'b0);
        end

        run_op(16'h0003, 16'h0005, 1'b0, 16'hfffe, 1'b1, 1'b0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
